// File: rtl/voter_pkg.sv
// Shared state type and width helpers for the sequential voter tally block.
package voter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      TALLY = 2'd2,
      DONE  = 2'd3
   } vote_state_e;

   // clog2 clamped to at least one bit so single-value fields stay legal
   function automatic int maxClog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int idWidth(input int nVoters);
      return maxClog2(nVoters);
   endfunction

   function automatic int candWidth(input int nCand);
      return maxClog2(nCand);
   endfunction

   function automatic int cntWidth(input int nVoters);
      return $clog2(nVoters + 1);
   endfunction

endpackage

// File: rtl/voter_argmax_scan.sv
// Serial argmax over a packed tally vector: one candidate per cycle after start,
// lowest index kept on ties, one-cycle done pulse after the last candidate.
module voter_argmax_scan
   import voter_pkg::*;
#(
   parameter int N_CAND = 3,
   parameter int CNT_W  = 3,
   parameter int CAND_W = candWidth(N_CAND)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [N_CAND*CNT_W-1:0]   tally_i,
   output logic                      done_o,
   output logic [CAND_W-1:0]         winner_o,
   output logic [CNT_W-1:0]          win_cnt_o,
   output logic                      tie_o
);

   localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(N_CAND - 1);

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CAND_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]  best_q, best_d;
   logic [CAND_W-1:0] win_q, win_d;
   logic              tie_q, tie_d;
   logic [CNT_W-1:0]  cur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         idx_q  <= '0;
         best_q <= '0;
         win_q  <= '0;
         tie_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         idx_q  <= idx_d;
         best_q <= best_d;
         win_q  <= win_d;
         tie_q  <= tie_d;
      end
   end

   // Constant-index mux keeps the tally select in range for any N_CAND
   always_comb begin
      cur = '0;
      for (int c = 0; c < N_CAND; c++) begin
         if (idx_q == CAND_W'(c)) begin
            cur = tally_i[c*CNT_W +: CNT_W];
         end
      end
   end

   always_comb begin
      busy_d = busy_q;
      done_d = 1'b0;
      idx_d  = idx_q;
      best_d = best_q;
      win_d  = win_q;
      tie_d  = tie_q;
      if (start_i) begin
         busy_d = 1'b1;
         idx_d  = '0;
         best_d = '0;
         win_d  = '0;
         tie_d  = 1'b0;
      end else if (busy_q) begin
         if (cur > best_q) begin
            best_d = cur;
            win_d  = idx_q;
            tie_d  = 1'b0;
         end else if ((cur == best_q) && (best_q != '0)) begin
            tie_d = 1'b1;
         end
         if (idx_q == LAST_IDX) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            idx_d = idx_q + CAND_W'(1);
         end
      end
   end

   assign done_o    = done_q;
   assign winner_o  = win_q;
   assign win_cnt_o = best_q;
   assign tie_o     = tie_q;

endmodule

// File: rtl/voter_tally_seq.sv
// Voting session controller: collects one vote per voter over valid/ready,
// then runs a serial argmax and holds winner, count, tie and majority flags.
module voter_tally_seq
   import voter_pkg::*;
#(
   parameter int N_VOTERS = 4,
   parameter int N_CAND   = 3,
   parameter int ID_W     = idWidth(N_VOTERS),
   parameter int CAND_W   = candWidth(N_CAND),
   parameter int CNT_W    = cntWidth(N_VOTERS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              close,
   input  logic              vote_valid,
   input  logic [ID_W-1:0]   vote_id,
   input  logic [CAND_W-1:0] vote_cand,
   output logic              vote_ready,
   output logic              vote_ack,
   output logic              vote_rej,
   output logic              busy,
   output logic              result_valid,
   output logic [CAND_W-1:0] winner,
   output logic [CNT_W-1:0]  win_cnt,
   output logic              tie,
   output logic              majority
);

   vote_state_e                  state_q, state_d;
   logic [N_VOTERS-1:0]          bitmap_q, bitmap_d;
   logic [N_CAND-1:0][CNT_W-1:0] tally_q, tally_d;
   logic                         ack_q, ack_d;
   logic                         rej_q, rej_d;
   logic [CAND_W-1:0]            winner_q, winner_d;
   logic [CNT_W-1:0]             win_cnt_q, win_cnt_d;
   logic                         tie_q, tie_d;
   logic                         maj_q, maj_d;

   logic                         xfer;
   logic                         idLegal;
   logic                         candLegal;
   logic                         alreadyVoted;
   logic                         accept;
   logic                         scanStart;
   logic                         scanDone;
   logic [CAND_W-1:0]            scanWinner;
   logic [CNT_W-1:0]             scanCnt;
   logic                         scanTie;
   logic [N_CAND*CNT_W-1:0]      tallyFlat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bitmap_q  <= '0;
         tally_q   <= '0;
         ack_q     <= 1'b0;
         rej_q     <= 1'b0;
         winner_q  <= '0;
         win_cnt_q <= '0;
         tie_q     <= 1'b0;
         maj_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitmap_q  <= bitmap_d;
         tally_q   <= tally_d;
         ack_q     <= ack_d;
         rej_q     <= rej_d;
         winner_q  <= winner_d;
         win_cnt_q <= win_cnt_d;
         tie_q     <= tie_d;
         maj_q     <= maj_d;
      end
   end

   // Vote legality; the bitmap lookup loops so an out-of-range id never indexes past the array
   always_comb begin
      xfer         = vote_valid && (state_q == OPEN);
      idLegal      = int'(vote_id) < N_VOTERS;
      candLegal    = int'(vote_cand) < N_CAND;
      alreadyVoted = 1'b0;
      for (int i = 0; i < N_VOTERS; i++) begin
         if (vote_id == ID_W'(i)) begin
            alreadyVoted = bitmap_q[i];
         end
      end
      accept = xfer && idLegal && candLegal && !alreadyVoted;
   end

   always_comb begin
      state_d   = state_q;
      bitmap_d  = bitmap_q;
      tally_d   = tally_q;
      ack_d     = 1'b0;
      rej_d     = 1'b0;
      winner_d  = winner_q;
      win_cnt_d = win_cnt_q;
      tie_d     = tie_q;
      maj_d     = maj_q;
      scanStart = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = OPEN;
               bitmap_d  = '0;
               tally_d   = '0;
               winner_d  = '0;
               win_cnt_d = '0;
               tie_d     = 1'b0;
               maj_d     = 1'b0;
            end
         end
         OPEN: begin
            if (xfer) begin
               ack_d = accept;
               rej_d = !accept;
            end
            if (accept) begin
               for (int i = 0; i < N_VOTERS; i++) begin
                  if (vote_id == ID_W'(i)) begin
                     bitmap_d[i] = 1'b1;
                  end
               end
               for (int c = 0; c < N_CAND; c++) begin
                  if (vote_cand == CAND_W'(c)) begin
                     tally_d[c] = tally_q[c] + CNT_W'(1);
                  end
               end
            end
            // A vote arriving with close is still counted before the scan starts
            if (close || (accept && (&bitmap_d))) begin
               state_d   = TALLY;
               scanStart = 1'b1;
            end
         end
         TALLY: begin
            if (scanDone) begin
               state_d   = DONE;
               winner_d  = scanWinner;
               win_cnt_d = scanCnt;
               tie_d     = scanTie;
               maj_d     = ((int'(scanCnt) * 2) > N_VOTERS) && !scanTie;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tallyFlat = tally_q;

   voter_argmax_scan #(
      .N_CAND (N_CAND),
      .CNT_W  (CNT_W),
      .CAND_W (CAND_W)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .start_i   (scanStart),
      .tally_i   (tallyFlat),
      .done_o    (scanDone),
      .winner_o  (scanWinner),
      .win_cnt_o (scanCnt),
      .tie_o     (scanTie)
   );

   assign vote_ready   = (state_q == OPEN);
   assign busy         = (state_q == OPEN) || (state_q == TALLY);
   assign result_valid = (state_q == DONE);
   assign vote_ack     = ack_q;
   assign vote_rej     = rej_q;
   assign winner       = winner_q;
   assign win_cnt      = win_cnt_q;
   assign tie          = tie_q;
   assign majority     = maj_q;

endmodule

// File: tb/tb_voter_tally_seq.sv
// Scoreboard bench for voter_tally_seq: directed sessions plus random ones,
// expected ack/rej and results come from a plain array model of the voting rules.
module tb_voter_tally_seq;

   localparam int NV = 4;
   localparam int NC = 3;

   typedef struct {
      int winner;
      int cnt;
      int tie;
      int maj;
      int due;
   } res_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic       close;
   logic       vote_valid;
   logic [1:0] vote_id;
   logic [1:0] vote_cand;
   logic       vote_ready;
   logic       vote_ack;
   logic       vote_rej;
   logic       busy;
   logic       result_valid;
   logic [1:0] winner;
   logic [2:0] win_cnt;
   logic       tie;
   logic       majority;

   int   checks;
   int   failures;
   int   cycle;
   bit   voteQ[$];
   res_t resQ[$];
   res_t lastExp;
   int   mTally[NC];
   bit   mVoted[NV];
   bit   sessOpen;

   voter_tally_seq dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .close        (close),
      .vote_valid   (vote_valid),
      .vote_id      (vote_id),
      .vote_cand    (vote_cand),
      .vote_ready   (vote_ready),
      .vote_ack     (vote_ack),
      .vote_rej     (vote_rej),
      .busy         (busy),
      .result_valid (result_valid),
      .winner       (winner),
      .win_cnt      (win_cnt),
      .tie          (tie),
      .majority     (majority)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result: highest tally, first index among equals, tie when a nonzero max is shared
   function automatic res_t modelResult();
      res_t r;
      int best;
      int nBest;
      best = 0;
      r.winner = 0;
      for (int c = 0; c < NC; c++) begin
         if (mTally[c] > best) begin
            best = mTally[c];
            r.winner = c;
         end
      end
      nBest = 0;
      for (int c = 0; c < NC; c++) begin
         if (mTally[c] == best) nBest++;
      end
      r.cnt = best;
      r.tie = (best > 0 && nBest >= 2) ? 1 : 0;
      r.maj = (2 * best > NV && r.tie == 0) ? 1 : 0;
      r.due = 0;
      return r;
   endfunction

   task automatic pushResult();
      res_t r;
      r = modelResult();
      r.due = cycle + NC + 1;
      resQ.push_back(r);
      lastExp = r;
      sessOpen = 1'b0;
   endtask

   task automatic startSession();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < NC; c++) mTally[c] = 0;
      for (int i = 0; i < NV; i++) mVoted[i] = 1'b0;
      sessOpen = 1'b1;
   endtask

   task automatic applyStimulus(input int id, input int cand, input bit doClose);
      bit acc;
      bit all;
      vote_valid = 1'b1;
      vote_id    = 2'(id);
      vote_cand  = 2'(cand);
      close      = doClose;
      acc = (id < NV) && (cand < NC) && !mVoted[id];
      voteQ.push_back(acc);
      if (acc) begin
         mVoted[id] = 1'b1;
         mTally[cand]++;
      end
      tick();
      vote_valid = 1'b0;
      close      = 1'b0;
      all = 1'b1;
      for (int i = 0; i < NV; i++) all &= mVoted[i];
      if (doClose || (acc && all)) pushResult();
   endtask

   task automatic closeOnly();
      close = 1'b1;
      tick();
      close = 1'b0;
      pushResult();
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((voteQ.size() > 0 || resQ.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      if (voteQ.size() > 0 || resQ.size() > 0) begin
         checkOutput("drain_timeout", voteQ.size() + resQ.size(), 0);
         voteQ.delete();
         resQ.delete();
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, int'(vote_ready), 0);
      checkOutput({tag, "_ack"}, int'(vote_ack), 0);
      checkOutput({tag, "_rej"}, int'(vote_rej), 0);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_rv"}, int'(result_valid), 0);
      checkOutput({tag, "_winner"}, int'(winner), 0);
      checkOutput({tag, "_wincnt"}, int'(win_cnt), 0);
      checkOutput({tag, "_tie"}, int'(tie), 0);
      checkOutput({tag, "_maj"}, int'(majority), 0);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a response or a fresh result
   logic prevRv;
   always @(negedge clk) begin
      if (rst) begin
         prevRv = 1'b0;
      end else begin
         if (vote_ack || vote_rej) begin
            if (voteQ.size() == 0) begin
               checkOutput("unexpected_resp", int'({vote_ack, vote_rej}), 0);
            end else begin
               bit e;
               e = voteQ.pop_front();
               checkOutput("vote_resp", int'({vote_ack, vote_rej}), e ? 2 : 1);
            end
         end
         if (result_valid && !prevRv) begin
            if (resQ.size() == 0) begin
               checkOutput("unexpected_result", 1, 0);
            end else begin
               res_t r;
               r = resQ.pop_front();
               checkOutput("res_cycle", cycle, r.due);
               checkOutput("res_winner", int'(winner), r.winner);
               checkOutput("res_wincnt", int'(win_cnt), r.cnt);
               checkOutput("res_tie", int'(tie), r.tie);
               checkOutput("res_maj", int'(majority), r.maj);
            end
         end
         prevRv = result_valid;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks     = 0;
      failures   = 0;
      cycle      = 0;
      rst        = 1'b1;
      start      = 1'b0;
      close      = 1'b0;
      vote_valid = 1'b0;
      vote_id    = '0;
      vote_cand  = '0;
      sessOpen   = 1'b0;
      tick();
      tick();
      checkAllZero("por");
      rst = 1'b0;
      tick();

      // Reset in the middle of an open session
      startSession();
      applyStimulus(0, 1, 1'b0);
      applyStimulus(1, 2, 1'b0);
      waitIdle(5);
      rst = 1'b1;
      #1;
      checkAllZero("midrst");
      tick();
      rst = 1'b0;
      sessOpen = 1'b0;
      tick();
      checkAllZero("postrst");

      // Full turnout, auto close on the last voter
      startSession();
      checkOutput("open_ready", int'(vote_ready), 1);
      checkOutput("open_busy", int'(busy), 1);
      applyStimulus(0, 1, 1'b0);
      applyStimulus(1, 1, 1'b0);
      applyStimulus(2, 2, 1'b0);
      applyStimulus(3, 1, 1'b0);
      waitIdle(20);

      // Double vote and illegal candidate
      startSession();
      applyStimulus(0, 1, 1'b0);
      applyStimulus(0, 1, 1'b0);
      applyStimulus(1, 3, 1'b0);
      closeOnly();
      waitIdle(20);

      // Tie between candidates 0 and 2
      startSession();
      applyStimulus(0, 0, 1'b0);
      applyStimulus(1, 2, 1'b0);
      applyStimulus(2, 2, 1'b0);
      applyStimulus(3, 0, 1'b0);
      waitIdle(20);

      // Early close with no votes
      startSession();
      closeOnly();
      waitIdle(20);

      // Close together with a vote
      startSession();
      applyStimulus(0, 2, 1'b1);
      waitIdle(20);

      // DONE ignores votes and holds results; start clears them
      vote_valid = 1'b1;
      vote_id    = 2'd1;
      vote_cand  = 2'd0;
      tick();
      vote_valid = 1'b0;
      checkOutput("done_ack", int'(vote_ack), 0);
      checkOutput("done_rej", int'(vote_rej), 0);
      checkOutput("done_rv", int'(result_valid), 1);
      checkOutput("done_winner", int'(winner), lastExp.winner);
      checkOutput("done_wincnt", int'(win_cnt), lastExp.cnt);
      startSession();
      checkOutput("restart_rv", int'(result_valid), 0);
      checkOutput("restart_wincnt", int'(win_cnt), 0);
      checkOutput("restart_ready", int'(vote_ready), 1);
      applyStimulus(3, 0, 1'b0);
      closeOnly();
      waitIdle(20);

      // Random sessions
      for (int s = 0; s < 40; s++) begin
         int guard;
         startSession();
         guard = 0;
         while (sessOpen && guard < 40) begin
            int pick;
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
               tick();
            end else if (pick == 1 && guard > 2) begin
               closeOnly();
            end else begin
               applyStimulus($urandom_range(0, NV - 1), $urandom_range(0, 3),
                             ($urandom_range(0, 15) == 0));
            end
            guard++;
         end
         if (sessOpen) closeOnly();
         waitIdle(20);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
